// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR random source:
//   lfsr_fsm_t     : output FSM states (WARM while discarding warm-up steps,
//                    RUN while producing samples)
//   LFSR_MAX_TAPS  : max-length Galois feedback masks for widths 4..32,
//                    bit i set means tap x^(i+1)
//   lfsr_next()    : one Galois step on a right-shifting register
// ----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } lfsr_fsm_t;

    localparam logic [31:0] LFSR_MAX_TAPS [4:32] = '{
        32'h0000_000C,  // 4 : 4,3
        32'h0000_0014,  // 5 : 5,3
        32'h0000_0030,  // 6 : 6,5
        32'h0000_0060,  // 7 : 7,6
        32'h0000_00B8,  // 8 : 8,6,5,4
        32'h0000_0110,  // 9 : 9,5
        32'h0000_0240,  // 10: 10,7
        32'h0000_0500,  // 11: 11,9
        32'h0000_0829,  // 12: 12,6,4,1
        32'h0000_100D,  // 13: 13,4,3,1
        32'h0000_2015,  // 14: 14,5,3,1
        32'h0000_6000,  // 15: 15,14
        32'h0000_B400,  // 16: 16,14,13,11
        32'h0001_2000,  // 17: 17,14
        32'h0002_0400,  // 18: 18,11
        32'h0004_0023,  // 19: 19,6,2,1
        32'h0009_0000,  // 20: 20,17
        32'h0014_0000,  // 21: 21,19
        32'h0030_0000,  // 22: 22,21
        32'h0042_0000,  // 23: 23,18
        32'h00E1_0000,  // 24: 24,23,22,17
        32'h0120_0000,  // 25: 25,22
        32'h0200_0023,  // 26: 26,6,2,1
        32'h0400_0013,  // 27: 27,5,2,1
        32'h0900_0000,  // 28: 28,25
        32'h1400_0000,  // 29: 29,27
        32'h2000_0029,  // 30: 30,6,4,1
        32'h4800_0000,  // 31: 31,28
        32'h8020_0003   // 32: 32,22,2,1
    };

    // Narrower registers are zero-extended by the caller, so the shift never
    // pulls garbage into the live bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps);
        return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// ----------------------------------------------------------------------------
// lfsr_rng_if
// Sample output channel of lfsr_rng.
//   out_valid / out_ready : a sample transfers on a clock edge where both are
//                           high; while out_valid is high and out_ready is low
//                           the producer holds out_data/out_idx stable and
//                           keeps out_valid high.
//   out_data              : random word (OUT_W bits)
//   out_idx               : out_data % NWAY (IDX_W bits)
// master = producer (lfsr_rng), slave = consumer.
// ----------------------------------------------------------------------------
interface lfsr_rng_if #(
    parameter int OUT_W = 8,
    parameter int IDX_W = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;

    modport master (output out_valid, output out_data, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/lfsr_core.sv
// ----------------------------------------------------------------------------
// lfsr_core
// LFSR state register with Galois step, seed load and lock-up guard.
// Ports:
//   clock, reset  : clock; synchronous active-high reset (state <= SEED)
//   step          : advance one Galois step this cycle
//   load          : load seed_in (wins over step)
//   seed_in       : requested seed; 0 is replaced by SEED
//   state         : current LFSR state
//   state_nxt     : value a step would load (SEED if state is 0)
//   seed_eff      : value a load would write (seed_in, or SEED for 0)
// ----------------------------------------------------------------------------
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_MAX_TAPS[WIDTH][WIDTH-1:0],
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] state_nxt,
    output logic [WIDTH-1:0] seed_eff
);

    logic [WIDTH-1:0] stepped;

    assign stepped   = WIDTH'(lfsr_next(32'(state), 32'(TAPS)));
    // An all-zero state is a fixed point of the LFSR; escape it via SEED.
    assign state_nxt = (state == '0) ? SEED : stepped;
    assign seed_eff  = (seed_in == '0) ? SEED : seed_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEED;
        end else if (load) begin
            state <= seed_eff;
        end else if (step) begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// ----------------------------------------------------------------------------
// lfsr_rng
// Galois-LFSR random source with seed load, warm-up and a valid/ready output.
// Ports:
//   clock, reset   : clock; synchronous active-high reset
//   en             : advance enable; low freezes state, counters and output
//   seed_we        : load seed_in this cycle (priority over all but reset)
//   seed_in        : new seed; 0 is replaced by SEED
//   out_if         : lfsr_rng_if.master (out_valid/out_ready/out_data/out_idx)
//   draw_cnt       : completed handshakes, wraps at 2^32   (LFSR_STATS_EN)
//   wrap_pulse     : one cycle high when a RUN step returns
//                    to the state snapshotted on entering RUN (LFSR_STATS_EN)
//   dbg_state      : current LFSR state
//   dbg_fsm        : current FSM state
// Build option: define LFSR_STATS_EN to add draw_cnt and wrap_pulse.
// ----------------------------------------------------------------------------
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
    parameter int               OUT_W  = 8,
    parameter int               NWAY   = 4,
    parameter int               WARMUP = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    lfsr_rng_if.master       out_if,
`ifdef LFSR_STATS_EN
    output logic [31:0]      draw_cnt,
    output logic             wrap_pulse,
`endif
    output logic [WIDTH-1:0] dbg_state,
    output lfsr_fsm_t        dbg_fsm
);

    localparam int          IDX_W    = (NWAY > 1) ? $clog2(NWAY) : 1;
    localparam lfsr_fsm_t   FSM_INIT = (WARMUP == 0) ? RUN : WARM;
    localparam logic [31:0] NWAY_U   = 32'(NWAY);
    localparam logic [31:0] WARM_END = 32'(WARMUP - 1);

    lfsr_fsm_t        fsm_q;
    logic [31:0]      warm_cnt;
    logic             valid_q;
    logic [OUT_W-1:0] data_q;

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_nxt;
    logic [WIDTH-1:0] seed_eff;

    logic take;
    logic run_fill;
    logic warm_step;
    logic warm_last;
    logic core_step;

    assign take      = valid_q && out_if.out_ready;
    // The slot is free when empty or being consumed this same edge.
    assign run_fill  = (fsm_q == RUN) && en && (!valid_q || out_if.out_ready);
    assign warm_step = (fsm_q == WARM) && en;
    assign warm_last = (warm_cnt == WARM_END);
    assign core_step = !seed_we && (warm_step || run_fill);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .step      (core_step),
        .load      (seed_we),
        .seed_in   (seed_in),
        .state     (state),
        .state_nxt (state_nxt),
        .seed_eff  (seed_eff)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q    <= FSM_INIT;
            warm_cnt <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else if (seed_we) begin
            // Any pending sample is dropped; out_data keeps its last value.
            fsm_q    <= FSM_INIT;
            warm_cnt <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (fsm_q)
                WARM: begin
                    if (en) begin
                        warm_cnt <= warm_cnt + 32'd1;
                        if (warm_last) begin
                            fsm_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (run_fill) begin
                        data_q  <= state[OUT_W-1:0];
                        valid_q <= 1'b1;
                    end else if (take) begin
                        // Consumer took the sample while en is low: no refill.
                        valid_q <= 1'b0;
                    end
                end
                default: fsm_q <= FSM_INIT;
            endcase
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;

    logic [31:0] data_ext;
    assign data_ext = 32'(data_q);

    generate
        if (NWAY == 1) begin : g_idx_one
            assign out_if.out_idx = '0;
        end else if ((NWAY & (NWAY - 1)) == 0) begin : g_idx_pow2
            assign out_if.out_idx = IDX_W'(data_ext);
        end else begin : g_idx_mod
            assign out_if.out_idx = IDX_W'(data_ext % NWAY_U);
        end
    endgenerate

`ifdef LFSR_STATS_EN
    logic [WIDTH-1:0] snap_q;

    // snap_q holds the state RUN started from; seeing it again after a RUN
    // step means one full LFSR period has been drawn.
    always_ff @(posedge clock) begin
        if (reset) begin
            draw_cnt   <= '0;
            wrap_pulse <= 1'b0;
            snap_q     <= SEED;
        end else if (seed_we) begin
            draw_cnt   <= '0;
            wrap_pulse <= 1'b0;
            snap_q     <= seed_eff;
        end else begin
            wrap_pulse <= 1'b0;
            if (take) begin
                draw_cnt <= draw_cnt + 32'd1;
            end
            if (warm_step && warm_last) begin
                snap_q <= state_nxt;
            end
            if (run_fill && (state_nxt == snap_q)) begin
                wrap_pulse <= 1'b1;
            end
        end
    end
`endif

    assign dbg_state = state;
    assign dbg_fsm   = fsm_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// ----------------------------------------------------------------------------
// tb_lfsr_rng
// Directed and scoreboarded checks of lfsr_rng. Two default-width instances
// share all inputs (NWAY=4 and NWAY=3); with LFSR_STATS_EN a 4-bit instance
// checks the period pulse and draw counter.
// ----------------------------------------------------------------------------
module tb_lfsr_rng;
    import lfsr_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        en      = 1'b0;
    logic        seed_we = 1'b0;
    logic [15:0] seed_in = '0;
    logic        ready   = 1'b0;

    lfsr_rng_if #(.OUT_W(8), .IDX_W(2)) a_if ();
    lfsr_rng_if #(.OUT_W(8), .IDX_W(2)) b_if ();
    assign a_if.out_ready = ready;
    assign b_if.out_ready = ready;

    logic [15:0] a_state, b_state;
    lfsr_fsm_t   a_fsm, b_fsm;

`ifdef LFSR_STATS_EN
    logic [31:0] a_draw, b_draw, c_draw;
    logic        a_wrap, b_wrap, c_wrap;
`endif

    lfsr_rng #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .OUT_W(8), .NWAY(4), .WARMUP(4)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .seed_we   (seed_we),
        .seed_in   (seed_in),
        .out_if    (a_if),
`ifdef LFSR_STATS_EN
        .draw_cnt  (a_draw),
        .wrap_pulse(a_wrap),
`endif
        .dbg_state (a_state),
        .dbg_fsm   (a_fsm)
    );

    lfsr_rng #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .OUT_W(8), .NWAY(3), .WARMUP(4)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .seed_we   (seed_we),
        .seed_in   (seed_in),
        .out_if    (b_if),
`ifdef LFSR_STATS_EN
        .draw_cnt  (b_draw),
        .wrap_pulse(b_wrap),
`endif
        .dbg_state (b_state),
        .dbg_fsm   (b_fsm)
    );

`ifdef LFSR_STATS_EN
    logic       c_en    = 1'b0;
    logic       c_ready = 1'b0;
    logic [3:0] c_state;
    lfsr_fsm_t  c_fsm;
    lfsr_rng_if #(.OUT_W(4), .IDX_W(2)) c_if ();
    assign c_if.out_ready = c_ready;

    lfsr_rng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4), .NWAY(4), .WARMUP(0)) dut_c (
        .clock     (clock),
        .reset     (reset),
        .en        (c_en),
        .seed_we   (1'b0),
        .seed_in   (4'h0),
        .out_if    (c_if),
        .draw_cnt  (c_draw),
        .wrap_pulse(c_wrap),
        .dbg_state (c_state),
        .dbg_fsm   (c_fsm)
    );
`endif

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    logic [15:0] warm_tab [4];
    logic [15:0] m_state;
    logic        m_valid;
    logic        fire;
    logic [7:0]  exp_d;
    int          pulse_at;

    initial begin
        warm_tab[0] = 16'hB400;
        warm_tab[1] = 16'h5A00;
        warm_tab[2] = 16'h2D00;
        warm_tab[3] = 16'h1680;

        // reset
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", 32'(a_state), 32'h0001);
        check("rst_valid", 32'(a_if.out_valid), 32'h0);
        check("rst_data",  32'(a_if.out_data), 32'h0);
        check("rst_fsm",   32'(a_fsm), 32'(WARM));

        // warm-up: four steps, no output
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("warm_state", 32'(a_state), 32'(warm_tab[i]));
            check("warm_valid", 32'(a_if.out_valid), 32'h0);
        end

        // first sample, then held while not ready
        tick();
        check("first_valid", 32'(a_if.out_valid), 32'h1);
        check("first_data",  32'(a_if.out_data), 32'h80);
        check("first_idx4",  32'(a_if.out_idx), 32'h0);
        check("first_idx3",  32'(b_if.out_idx), 32'h2);
        check("first_state", 32'(a_state), 32'h0B40);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 32'(a_if.out_valid), 32'h1);
            check("hold_data",  32'(a_if.out_data), 32'h80);
            check("hold_state", 32'(a_state), 32'h0B40);
        end

        // handshake: next sample with NWAY=3 index
        ready = 1'b1;
        tick();
        check("second_data",  32'(b_if.out_data), 32'h40);
        check("second_idx3",  32'(b_if.out_idx), 32'h1);
        check("second_state", 32'(b_state), 32'h05A0);

        // en low: frozen; one handshake clears valid with no refill
        en    = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("frz_state", 32'(a_state), 32'h05A0);
            check("frz_data",  32'(a_if.out_data), 32'h40);
            check("frz_valid", 32'(a_if.out_valid), 32'h1);
        end
        ready = 1'b1;
        tick();
        check("frz_take_valid", 32'(a_if.out_valid), 32'h0);
        check("frz_take_state", 32'(a_state), 32'h05A0);
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("frz_idle_valid", 32'(a_if.out_valid), 32'h0);
            check("frz_idle_state", 32'(a_state), 32'h05A0);
        end

        // random en/ready against the reference model
        m_state = 16'h05A0;
        m_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            ready = $urandom_range(0, 1) != 0;
            check("sb_valid", 32'(a_if.out_valid), 32'(m_valid));
            fire = m_valid && ready;
            if (fire) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    exp_d = exp_q.pop_front();
                    check("sb_data", 32'(a_if.out_data), 32'(exp_d));
                    check("sb_idx4", 32'(a_if.out_idx), 32'(exp_d) % 4);
                    check("sb_idx3", 32'(b_if.out_idx), 32'(exp_d) % 3);
                end
            end
            if (en && (!m_valid || ready)) begin
                exp_q.push_back(m_state[7:0]);
                m_state = ref_step(m_state);
                m_valid = 1'b1;
            end else if (fire) begin
                m_valid = 1'b0;
            end
            tick();
            check("sb_state", 32'(a_state), 32'(m_state));
        end

        // seed 0 mid-RUN with a sample pending
        en    = 1'b1;
        ready = 1'b0;
        tick();
        check("pend_valid", 32'(a_if.out_valid), 32'h1);
        seed_we = 1'b1;
        seed_in = 16'h0000;
        tick();
        seed_we = 1'b0;
        exp_q.delete();
        check("seed0_valid", 32'(a_if.out_valid), 32'h0);
        check("seed0_state", 32'(a_state), 32'h0001);
        check("seed0_fsm",   32'(a_fsm), 32'(WARM));
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rewarm_valid", 32'(a_if.out_valid), 32'h0);
        end
        check("rewarm_state", 32'(a_state), 32'h1680);
        tick();
        check("reseed_valid", 32'(a_if.out_valid), 32'h1);
        check("reseed_data",  32'(a_if.out_data), 32'h80);

        // nonzero seed is loaded as given
        seed_we = 1'b1;
        seed_in = 16'h1234;
        tick();
        seed_we = 1'b0;
        en      = 1'b0;
        check("seedx_state", 32'(a_state), 32'h1234);
        check("seedx_valid", 32'(a_if.out_valid), 32'h0);

        // reset mid-run
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_state", 32'(a_state), 32'h0001);
        check("rst2_valid", 32'(a_if.out_valid), 32'h0);
        check("rst2_data",  32'(a_if.out_data), 32'h0);

`ifdef LFSR_STATS_EN
        // 4-bit max-length LFSR: period 15
        check("c_rst_draw", c_draw, 32'h0);
        c_en     = 1'b1;
        c_ready  = 1'b1;
        pulse_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (c_wrap) begin
                pulse_at = i;
                break;
            end
        end
        check("c_wrap_at", 32'(pulse_at), 32'd15);
        tick();
        check("c_draw_cnt", c_draw, 32'd15);
        check("c_wrap_clr", 32'(c_wrap), 32'h0);
        c_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
